// File: rtl/serial_logic_pkg.sv
// rtl/serial_logic_pkg.sv - shared state encoding and truth-table constants for serial_logic_unit
package serial_logic_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Truth tables indexed by {a,b}; bit 3 is the a=1,b=1 output.
  localparam logic [3:0] FN_AND  = 4'b1000;
  localparam logic [3:0] FN_OR   = 4'b1110;
  localparam logic [3:0] FN_XOR  = 4'b0110;
  localparam logic [3:0] FN_NOR  = 4'b0001;
  localparam logic [3:0] FN_NAND = 4'b0111;
  localparam logic [3:0] FN_F7   = 4'b1101;

endpackage

// File: rtl/lut2_cell.sv
// rtl/lut2_cell.sv - two-input lookup cell, y = fn[{a,b}]
module lut2_cell (
  input  logic [3:0] fn,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  assign y = fn[{a, b}];

endmodule

// File: rtl/serial_logic_unit.sv
// rtl/serial_logic_unit.sv - bit-serial two-input logic unit; ones output under SERIAL_LOGIC_POPCOUNT_EN
module serial_logic_unit
  import serial_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s
`ifdef SERIAL_LOGIC_POPCOUNT_EN
  ,
  output logic [CNT_W-1:0] ones
`endif
);

  // A 1-bit index keeps WIDTH=1 legal; it is only ever compared, never used to slice.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         fn_q, fn_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               a_bit, b_bit, y_bit;

  lut2_cell u_cell (
    .fn (fn_q),
    .a  (a_bit),
    .b  (b_bit),
    .y  (y_bit)
  );

  always_comb begin
    a_bit = 1'b0;
    b_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_bit = a_q[i];
        b_bit = b_q[i];
      end
    end
  end

`ifdef SERIAL_LOGIC_POPCOUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ones_q, ones_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    a_d     = a_q;
    b_d     = b_q;
    fn_d    = fn_q;
    s_d     = s_q;
`ifdef SERIAL_LOGIC_POPCOUNT_EN
    cnt_d   = cnt_q;
    ones_d  = ones_q;
`endif
    case (state_q)
      ST_RUN: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (idx_q == IDX_W'(i)) work_d[i] = y_bit;
        end
        idx_d = idx_q + IDX_W'(1);
`ifdef SERIAL_LOGIC_POPCOUNT_EN
        cnt_d = cnt_q + CNT_W'(y_bit);
`endif
        if (idx_q == IDX_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          s_d     = work_d;
`ifdef SERIAL_LOGIC_POPCOUNT_EN
          ones_d  = cnt_d;
`endif
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation, which makes back-to-back runs free.
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          work_d  = '0;
          a_d     = a;
          b_d     = b;
          fn_d    = fn;
`ifdef SERIAL_LOGIC_POPCOUNT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      work_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fn_q    <= '0;
      s_q     <= '0;
`ifdef SERIAL_LOGIC_POPCOUNT_EN
      cnt_q   <= '0;
      ones_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fn_q    <= fn_d;
      s_q     <= s_d;
`ifdef SERIAL_LOGIC_POPCOUNT_EN
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
`endif
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign s    = s_q;
`ifdef SERIAL_LOGIC_POPCOUNT_EN
  assign ones = ones_q;
`endif

endmodule

// File: tb/tb_serial_logic_unit.sv
// tb/tb_serial_logic_unit.sv - directed self-checking bench for serial_logic_unit (WIDTH=8 and WIDTH=1)
module tb_serial_logic_unit;
  import serial_logic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [3:0] fn8, fn1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, busy1, done1;
  logic [7:0] s8;
  logic [0:0] s1;
`ifdef SERIAL_LOGIC_POPCOUNT_EN
  logic [3:0] ones8;
  logic [0:0] ones1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_logic_unit #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .fn    (fn8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .s     (s8)
`ifdef SERIAL_LOGIC_POPCOUNT_EN
    ,
    .ones  (ones8)
`endif
  );

  serial_logic_unit #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .fn    (fn1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .s     (s1)
`ifdef SERIAL_LOGIC_POPCOUNT_EN
    ,
    .ones  (ones1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    fn8 = '0; a8 = '0; b8 = '0; fn1 = '0; a1 = '0; b1 = '0;
    tick(); tick();
    n_checks++;
    if ({busy8, done8, s8} !== 10'd0) begin
      n_fail++; $display("FAIL reset_w8 got busy=%b done=%b s=%h exp 0 0 00", busy8, done8, s8);
    end
    n_checks++;
    if ({busy1, done1, s1} !== 3'd0) begin
      n_fail++; $display("FAIL reset_w1 got busy=%b done=%b s=%h exp 0 0 0", busy1, done1, s1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nor();
    int busy_bad;
    fn8 = FN_NOR; a8 = 8'h0F; b8 = 8'h33; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    busy_bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy8 !== 1'b1 || done8 !== 1'b0) busy_bad++;
      tick();
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++; $display("FAIL nor_busy_window got %0d bad cycles exp 0", busy_bad);
    end
    n_checks++;
    if ({done8, busy8, s8} !== {1'b1, 1'b0, 8'hC0}) begin
      n_fail++; $display("FAIL nor_result got done=%b busy=%b s=%h exp 1 0 c0", done8, busy8, s8);
    end
    tick();
    n_checks++;
    if ({done8, s8} !== {1'b0, 8'hC0}) begin
      n_fail++; $display("FAIL nor_hold got done=%b s=%h exp 0 c0", done8, s8);
    end
  endtask

  task automatic test_f7_latency();
    int edges;
    fn8 = FN_F7; a8 = 8'hA5; b8 = 8'h3C; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    edges = 1;
    while (done8 !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    n_checks++;
    if (edges != 9) begin
      n_fail++; $display("FAIL f7_latency got %0d edges exp 9", edges);
    end
    n_checks++;
    if (s8 !== 8'hE7) begin
      n_fail++; $display("FAIL f7_result got %h exp e7", s8);
    end
`ifdef SERIAL_LOGIC_POPCOUNT_EN
    n_checks++;
    if (ones8 !== 4'd6) begin
      n_fail++; $display("FAIL f7_ones got %0d exp 6", ones8);
    end
`endif
    tick();
  endtask

  task automatic test_ignore_start();
    int edges;
    fn8 = FN_XOR; a8 = 8'hFF; b8 = 8'h0F; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    fn8 = FN_AND; a8 = 8'h00; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    edges = 4;
    while (done8 !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    n_checks++;
    if (edges != 9) begin
      n_fail++; $display("FAIL ignore_latency got %0d edges exp 9", edges);
    end
    n_checks++;
    if (s8 !== 8'hF0) begin
      n_fail++; $display("FAIL ignore_result got %h exp f0", s8);
    end
    tick();
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++; $display("FAIL ignore_idle got busy=%b exp 0", busy8);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    fn8 = FN_AND; a8 = 8'hF0; b8 = 8'h3C; start8 = 1'b1;
    tick();
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 8 || s8 !== 8'h30) begin
      n_fail++; $display("FAIL b2b_first got n=%0d s=%h exp 8 30", n, s8);
    end
    a8 = 8'hFF;
    tick();
    n_checks++;
    if ({busy8, done8} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_no_idle got busy=%b done=%b exp 1 0", busy8, done8);
    end
    n = 1;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 9 || s8 !== 8'h3C) begin
      n_fail++; $display("FAIL b2b_second got period=%0d s=%h exp 9 3c", n, s8);
    end
    start8 = 1'b0;
    tick();
    n_checks++;
    if ({busy8, done8} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_stop got busy=%b done=%b exp 0 0", busy8, done8);
    end
  endtask

  task automatic test_reset_midrun();
    int spurious;
    int n;
    fn8 = FN_OR; a8 = 8'h0F; b8 = 8'h33; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({busy8, done8, s8} !== 10'd0) begin
      n_fail++; $display("FAIL midrun_reset got busy=%b done=%b s=%h exp 0 0 00", busy8, done8, s8);
    end
    start8 = 1'b1;
    tick();
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++; $display("FAIL start_in_reset got busy=%b exp 0", busy8);
    end
    start8 = 1'b0;
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 !== 1'b0 || busy8 !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++; $display("FAIL midrun_no_done got %0d active cycles exp 0", spurious);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++; $display("FAIL first_edge_start got busy=%b exp 1", busy8);
    end
    n = 1;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 9 || s8 !== 8'h3F) begin
      n_fail++; $display("FAIL post_reset_op got n=%0d s=%h exp 9 3f", n, s8);
    end
    tick();
  endtask

  task automatic test_width1();
    fn1 = FN_NAND; a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_checks++;
    if ({busy1, done1} !== 2'b10) begin
      n_fail++; $display("FAIL w1_run got busy=%b done=%b exp 1 0", busy1, done1);
    end
    tick();
    n_checks++;
    if ({busy1, done1, s1} !== 3'b010) begin
      n_fail++; $display("FAIL w1_nand11 got busy=%b done=%b s=%b exp 0 1 0", busy1, done1, s1);
    end
    a1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    n_checks++;
    if ({done1, s1} !== 2'b11) begin
      n_fail++; $display("FAIL w1_nand01 got done=%b s=%b exp 1 1", done1, s1);
    end
`ifdef SERIAL_LOGIC_POPCOUNT_EN
    n_checks++;
    if (ones1 !== 1'b1) begin
      n_fail++; $display("FAIL w1_ones got %0d exp 1", ones1);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_nor();
    test_f7_latency();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
